// File: rtl/pll_reset_seq.sv
// pll_reset_seq: reset sequencer and lock monitor for a PLL fed from the board
// reference clock. It pulses the PLL reset and waits for lock. It qualifies
// lock as continuously stable before it releases the system reset. It
// re-sequences the PLL on lock loss, lock timeout or a software request.
// Optional feature macro: PLL_RST_SEQ_TIMEOUT_EN. When defined, WAIT_LOCK
// times out and retries, and retry_cnt counts the timeouts. When undefined,
// WAIT_LOCK waits indefinitely and retry_cnt is tied to 0.
module pll_reset_seq #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [3:0] retry_cnt,
    output logic       lock_lost
);

    // The shared counter must reach the largest terminal value of any state.
    localparam int MAX_A  = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_B  = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int MAX_P  = (MAX_B > 2) ? MAX_B : 2;
    localparam int CNT_W  = $clog2(MAX_P);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef PLL_RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lk_m;
    logic             lk_s;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
    logic [3:0]       retry_q;
`endif

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
        end else begin
            lk_m <= pll_locked;
            lk_s <= lk_m;
        end
    end

    // Sequencer FSM. The outputs are registered from the next state, so they change with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
            retry_q   <= 4'd0;
`endif
        end else if (soft_req) begin
            // A software restart overrides everything, including an ongoing PLL reset.
            state     <= S_PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state   <= S_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lk_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
                    end else if (cnt == WAIT_LAST) begin
                        state   <= S_PLL_RST;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        if (retry_q != 4'd15) begin
                            retry_q <= retry_q + 4'd1;
                        end
`endif
                    end else begin
                        // Without the timeout the count is unused here and may wrap.
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lk_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        sys_rst_n <= 1'b1;
                        ready     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lk_s) begin
                        state     <= S_PLL_RST;
                        cnt       <= '0;
                        pll_rst   <= 1'b1;
                        sys_rst_n <= 1'b0;
                        ready     <= 1'b0;
                        lock_lost <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_PLL_RST;
                    cnt       <= '0;
                    pll_rst   <= 1'b1;
                    sys_rst_n <= 1'b0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_RST_SEQ_TIMEOUT_EN
    assign retry_cnt = retry_q;
`else
    assign retry_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed testbench for pll_reset_seq with PLL_RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8. The timeout scenario follows PLL_RST_SEQ_TIMEOUT_EN.
module tb_pll_reset_seq;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic [3:0] retry_cnt;
    logic       lock_lost;

    int checks   = 0;
    int failures = 0;

    pll_reset_seq #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .soft_req  (soft_req),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .retry_cnt (retry_cnt),
        .lock_lost (lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int high_cnt;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        soft_req   = 1'b0;
        tick();
        tick();
        check("rst_pll_rst",   {7'd0, pll_rst},   8'd1);
        check("rst_sys_rst_n", {7'd0, sys_rst_n}, 8'd0);
        check("rst_ready",     {7'd0, ready},     8'd0);
        check("rst_retry",     {4'd0, retry_cnt}, 8'd0);
        check("rst_lock_lost", {7'd0, lock_lost}, 8'd0);

        // Nominal bring-up: pll_rst is held for 4 edges.
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("nom_pll_rst_e%0d", i), {7'd0, pll_rst}, (i < 4) ? 8'd1 : 8'd0);
        end
        repeat (6) tick();
        pll_locked = 1'b1;
        repeat (10) tick();
        check("nom_sys_rst_e10", {7'd0, sys_rst_n}, 8'd0);
        check("nom_ready_e10",   {7'd0, ready},     8'd0);
        tick();
        check("nom_sys_rst_e11", {7'd0, sys_rst_n}, 8'd1);
        check("nom_ready_e11",   {7'd0, ready},     8'd1);
        check("nom_pll_rst",     {7'd0, pll_rst},   8'd0);
        check("nom_retry",       {4'd0, retry_cnt}, 8'd0);
        check("nom_lock_lost",   {7'd0, lock_lost}, 8'd0);

        // Lock loss in RUN: the FSM reacts by the 3rd edge.
        pll_locked = 1'b0;
        repeat (3) tick();
        check("loss_sys_rst_n", {7'd0, sys_rst_n}, 8'd0);
        check("loss_ready",     {7'd0, ready},     8'd0);
        check("loss_pll_rst",   {7'd0, pll_rst},   8'd1);
        check("loss_lock_lost", {7'd0, lock_lost}, 8'd1);
        repeat (3) tick();
        check("loss_pll_rst_held", {7'd0, pll_rst}, 8'd1);
        tick();
        check("loss_pll_rst_rel", {7'd0, pll_rst}, 8'd0);

        // Relock with a 2-cycle dropout after 5 stable cycles.
        pll_locked = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 7) pll_locked = 1'b0;
            if (e == 9) pll_locked = 1'b1;
            if (e == 11) check("unst_sys_rst_e11", {7'd0, sys_rst_n}, 8'd0);
            if (e == 19) check("unst_sys_rst_e19", {7'd0, sys_rst_n}, 8'd0);
            if (e == 20) check("unst_sys_rst_e20", {7'd0, sys_rst_n}, 8'd1);
        end
        check("relock_lock_lost", {7'd0, lock_lost}, 8'd1);
        check("relock_ready",     {7'd0, ready},     8'd1);

        // Soft restart in RUN.
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        check("soft_pll_rst",   {7'd0, pll_rst},   8'd1);
        check("soft_sys_rst_n", {7'd0, sys_rst_n}, 8'd0);
        check("soft_ready",     {7'd0, ready},     8'd0);
        check("soft_retry",     {4'd0, retry_cnt}, 8'd0);
        check("soft_lock_lost", {7'd0, lock_lost}, 8'd1);
        // A second pulse inside PLL_RST restarts the 4-edge count.
        tick();
        tick();
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        repeat (3) tick();
        check("soft_restart_held", {7'd0, pll_rst}, 8'd1);
        tick();
        check("soft_restart_rel", {7'd0, pll_rst}, 8'd0);
        // Into STABLE, then assert rst_n between edges.
        repeat (3) tick();
        check("mid_stable_sys", {7'd0, sys_rst_n}, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pll_rst",   {7'd0, pll_rst},   8'd1);
        check("async_sys_rst_n", {7'd0, sys_rst_n}, 8'd0);
        check("async_ready",     {7'd0, ready},     8'd0);
        check("async_retry",     {4'd0, retry_cnt}, 8'd0);
        check("async_lock_lost", {7'd0, lock_lost}, 8'd0);

        // No lock at all after reset release.
        pll_locked = 1'b0;
        tick();
        rst_n = 1'b1;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
        for (int n = 1; n <= 17; n++) begin
            repeat (23) tick();
            check($sformatf("to_pll_rst_low_%0d", n), {7'd0, pll_rst}, 8'd0);
            check($sformatf("to_retry_pre_%0d", n), {4'd0, retry_cnt}, 8'(n - 1 > 15 ? 15 : n - 1));
            tick();
            check($sformatf("to_pll_rst_high_%0d", n), {7'd0, pll_rst}, 8'd1);
            check($sformatf("to_retry_%0d", n), {4'd0, retry_cnt}, 8'(n > 15 ? 15 : n));
        end
`else
        high_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (pll_rst) high_cnt++;
        end
        check("nto_pll_rst_edges", 8'(high_cnt), 8'd3);
        check("nto_pll_rst_final", {7'd0, pll_rst},   8'd0);
        check("nto_retry",         {4'd0, retry_cnt}, 8'd0);
        check("nto_sys_rst_n",     {7'd0, sys_rst_n}, 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
